line_echo: RTL and testbench
============================

LINE_ECHO -- requirements
Module: line_echo

Interface
REQ-001 SHALL have parameter LINE_LEN, default 64: line buffer depth in bytes; legal range 2..256.
REQ-002 SHALL have parameter TERM_CHAR, default 8'h0D: line terminator byte.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rstn_i, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port out_data_i, input, 8: host-to-device byte, driven by usb_cdc out_data_o.
REQ-006 SHALL have port out_valid_i, input, 1: out_data_i valid.
REQ-007 SHALL have port out_ready_o, output, 1: block accepts out_data_i.
REQ-008 SHALL have port in_data_o, output, 8: device-to-host byte, driven into usb_cdc in_data_i.
REQ-009 SHALL have port in_valid_o, output, 1: in_data_o valid.
REQ-010 SHALL have port in_ready_i, input, 1: usb_cdc accepts in_data_o.
REQ-011 SHALL have port busy_o, output, 1: high whenever state is not COLLECT.
REQ-012 SHALL have port lines_o, output, 16: count of completed line replays.

Function
REQ-013 SHALL define a transfer on either stream as valid and ready both high at a rising clk_i edge.
REQ-014 SHALL implement states COLLECT, REPLAY and SEND_LF.
REQ-015 In COLLECT, SHALL drive out_ready_o=1 and in_valid_o=0.
REQ-016 In COLLECT, each accepted byte SHALL be written to buffer[wr_ptr], and wr_ptr SHALL increment.
REQ-017 An accepted byte equal to TERM_CHAR, or an accepted byte at wr_ptr==LINE_LEN-1 (buffer full), SHALL latch len=wr_ptr+1 and move to REPLAY on the next cycle.
REQ-018 In REPLAY, SHALL drive out_ready_o=0, in_valid_o=1 and in_data_o=buffer[rd_ptr]; in_valid_o SHALL rise the cycle after the terminating byte is accepted.
REQ-019 While in_valid_o=1 and in_ready_i=0, in_data_o and in_valid_o SHALL hold stable.
REQ-020 Each IN transfer SHALL increment rd_ptr; back-to-back transfers SHALL sustain one byte per cycle.
REQ-021 When the transfer of byte len-1 completes, SHALL go to SEND_LF if enabled per REQ-030, otherwise to COLLECT; wr_ptr and rd_ptr SHALL clear to 0 and lines_o SHALL increment.
REQ-022 lines_o SHALL wrap from 16'hFFFF to 0.
REQ-023 A full-buffer line without a terminator SHALL replay exactly LINE_LEN bytes, with no LF.
REQ-024 An empty line (TERM_CHAR alone) SHALL replay exactly one byte.
REQ-025 Input bytes SHALL never be dropped: out_ready_o=0 outside COLLECT provides backpressure.
REQ-026 Pointer widths SHALL be $clog2(LINE_LEN)+1 bits; len SHALL be in the range 1..LINE_LEN.

Reset
REQ-027 While rstn_i=0, SHALL asynchronously force state=COLLECT, wr_ptr=0, rd_ptr=0, len=0, lines_o=0, in_valid_o=0, in_data_o=8'h00, busy_o=0 and out_ready_o=0.
REQ-028 SHALL drive out_ready_o=1 from the first rising edge after rstn_i deasserts; buffer contents SHALL not be reset.
REQ-029 Reset asserted during REPLAY or SEND_LF SHALL abort the line with no further IN transfers, and lines_o SHALL not increment for the aborted line.

Configuration
REQ-030 With macro LINE_ECHO_CRLF_EN defined, a replayed line whose last byte equals TERM_CHAR SHALL be followed by SEND_LF, presenting in_data_o=8'h0A, in_valid_o=1 and out_ready_o=0 until transferred, then moving to COLLECT; lines_o SHALL increment after the LF transfer rather than per REQ-021.
REQ-031 With LINE_ECHO_CRLF_EN undefined, the SEND_LF state SHALL not exist and no LF SHALL be emitted.

Verification
REQ-032 Input "AB\r" (41,42,0D) with in_ready_i=1 -> output 41,42,0D at one byte per cycle (plus 0A with CRLF_EN), then out_ready_o=1 and lines_o=1.
REQ-033 LINE_LEN=4, input 31,32,33,34,35 -> output 31..34, 35 stalled (out_ready_o=0) until replay done, then 35 accepted into a new line; no LF emitted.
REQ-034 Replay with in_ready_i toggling 1,0,0,1 -> in_data_o held stable across stalls; byte order and count unchanged.
REQ-035 Input 0D alone -> single output 0D (plus 0A with CRLF_EN); busy_o high exactly during the replay.
REQ-036 rstn_i pulsed low mid-REPLAY of "HELLO\r" -> in_valid_o=0 immediately, lines_o=0; next line "X\r" echoes correctly.
REQ-037 Preload lines_o to 16'hFFFF (65535 lines) -> next completed line gives lines_o=0.

Source files
------------

// File: rtl/line_echo.sv
// line_echo: collects bytes from the host into a line buffer. Each line is
// closed by TERM_CHAR or by the buffer filling up, and is then echoed back
// to the host. Input is held off (out_ready_o=0) while a line is replayed.
// Optional build macro LINE_ECHO_CRLF_EN: a line whose last byte is
// TERM_CHAR is followed by an extra LF (8'h0A) byte.
module line_echo #(
  parameter int          LINE_LEN  = 64,
  parameter logic [7:0]  TERM_CHAR = 8'h0D
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [7:0]  out_data_i,
  input  logic        out_valid_i,
  output logic        out_ready_o,
  output logic [7:0]  in_data_o,
  output logic        in_valid_o,
  input  logic        in_ready_i,
  output logic        busy_o,
  output logic [15:0] lines_o
);

  localparam int         PW       = $clog2(LINE_LEN) + 1;
  localparam int         AW       = $clog2(LINE_LEN);
  localparam logic [7:0] LF_CHAR  = 8'h0A;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_REPLAY
`ifdef LINE_ECHO_CRLF_EN
    , ST_SEND_LF
`endif
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [7:0]    r_buf [LINE_LEN];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_len;
  logic [15:0]   r_lines;
  logic          r_started;
`ifdef LINE_ECHO_CRLF_EN
  logic          r_term_last;
`endif

  logic w_out_xfer;
  logic w_in_xfer;
  logic w_line_end;
  logic w_last_byte;
  logic w_line_done;

  assign out_ready_o = r_started && (r_state == ST_COLLECT);
  assign in_valid_o  = (r_state != ST_COLLECT);
  assign busy_o      = (r_state != ST_COLLECT);
  assign lines_o     = r_lines;

  assign w_out_xfer  = out_valid_i && out_ready_o;
  assign w_in_xfer   = in_valid_o && in_ready_i;
  assign w_line_end  = (out_data_i == TERM_CHAR) || (r_wr_ptr == PW'(LINE_LEN - 1));
  assign w_last_byte = (r_rd_ptr == r_len - PW'(1));

`ifdef LINE_ECHO_CRLF_EN
  assign w_line_done = (r_state == ST_REPLAY && w_in_xfer && w_last_byte && !r_term_last) ||
                       (r_state == ST_SEND_LF && w_in_xfer);
`else
  assign w_line_done = (r_state == ST_REPLAY) && w_in_xfer && w_last_byte;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and the replay data mux.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    w_next_state = r_state;
    in_data_o    = 8'h00;
    case (r_state)
      ST_COLLECT: begin
        if (w_out_xfer && w_line_end) w_next_state = ST_REPLAY;
      end
      ST_REPLAY: begin
        in_data_o = r_buf[r_rd_ptr[AW-1:0]];
        if (w_in_xfer && w_last_byte) begin
`ifdef LINE_ECHO_CRLF_EN
          w_next_state = r_term_last ? ST_SEND_LF : ST_COLLECT;
`else
          w_next_state = ST_COLLECT;
`endif
        end
      end
`ifdef LINE_ECHO_CRLF_EN
      ST_SEND_LF: begin
        in_data_o = LF_CHAR;
        if (w_in_xfer) w_next_state = ST_COLLECT;
      end
`endif
      default: w_next_state = ST_COLLECT;
    endcase
  end

  // Pointers, latched line length and the completed-line counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_len       <= '0;
      r_lines     <= '0;
      r_started   <= 1'b0;
`ifdef LINE_ECHO_CRLF_EN
      r_term_last <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r_started <= 1'b1;
      if (w_out_xfer) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_line_end) begin
          r_len <= r_wr_ptr + PW'(1);
`ifdef LINE_ECHO_CRLF_EN
          r_term_last <= (out_data_i == TERM_CHAR);
`endif
        end
      end
      if ((r_state == ST_REPLAY) && w_in_xfer) begin
        if (w_last_byte) begin
          r_rd_ptr <= '0;
          r_wr_ptr <= '0;
        end else begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
      end
      if (w_line_done) r_lines <= r_lines + 16'd1;
    end
  end

  // Line buffer write port.
  // NOTE: the buffer is deliberately left out of reset; every byte is written
  // before it is replayed, so its power-up contents never reach the output.
  always_ff @(posedge clk_i) begin
    if (w_out_xfer) r_buf[r_wr_ptr[AW-1:0]] <= out_data_i;
  end

endmodule

// File: tb/tb_line_echo.sv
// Bench for line_echo: a queue-based model of the line/echo behaviour is
// compared against the DUT on every falling clock edge. Directed line
// scenarios with literal expectations are followed by randomized traffic.
module tb_line_echo;

  localparam int         LEN  = 8;
  localparam logic [7:0] TERM = 8'h0D;
`ifdef LINE_ECHO_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [7:0]  out_data_i;
  logic        out_valid_i;
  logic        out_ready_o;
  logic [7:0]  in_data_o;
  logic        in_valid_o;
  logic        in_ready_i;
  logic        busy_o;
  logic [15:0] lines_o;

  line_echo #(.LINE_LEN(LEN), .TERM_CHAR(TERM)) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .out_data_i (out_data_i),
    .out_valid_i(out_valid_i),
    .out_ready_o(out_ready_o),
    .in_data_o  (in_data_o),
    .in_valid_o (in_valid_o),
    .in_ready_i (in_ready_i),
    .busy_o     (busy_o),
    .lines_o    (lines_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: bytes of the line being collected, bytes still owed
  // to the host for the closed line, and the number of finished lines.
  logic [7:0]  cur_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  cap_q[$];
  logic [15:0] m_lines   = 16'd0;
  bit          m_started = 1'b0;
  bit          m_ready;
  logic [7:0]  m_dummy;

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cur_q.delete();
      exp_q.delete();
      m_lines   = 16'd0;
      m_started = 1'b0;
    end else begin
      m_ready = m_started && (exp_q.size() == 0);
      if (exp_q.size() != 0 && in_ready_i) begin
        m_dummy = exp_q.pop_front();
        if (exp_q.size() == 0) m_lines = m_lines + 16'd1;
      end
      if (m_ready && out_valid_i) begin
        cur_q.push_back(out_data_i);
        if (out_data_i == TERM || cur_q.size() == LEN) begin
          exp_q = cur_q;
          if (CRLF && out_data_i == TERM) exp_q.push_back(8'h0A);
          cur_q.delete();
        end
      end
      m_started = 1'b1;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk_i) begin
    if (!rstn_i) begin
      check("rst_in_valid", in_valid_o, 0);
      check("rst_in_data", in_data_o, 0);
      check("rst_out_ready", out_ready_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_lines", lines_o, 0);
    end else begin
      check("in_valid", in_valid_o, exp_q.size() != 0);
      check("busy", busy_o, exp_q.size() != 0);
      check("out_ready", out_ready_o, m_started && exp_q.size() == 0);
      check("lines", lines_o, m_lines);
      if (exp_q.size() != 0) check("in_data", in_data_o, exp_q[0]);
      if (in_valid_o && in_ready_i) cap_q.push_back(in_data_o);
    end
  end

  // Host-side ready: 0 = always ready, 1 = random, 2 = repeating 1,0,0,1.
  int ready_mode = 0;
  int ready_cnt  = 0;
  always @(posedge clk_i) begin
    #1;
    case (ready_mode)
      1:       in_ready_i = ($urandom_range(0, 9) < 7);
      2: begin
        in_ready_i = (ready_cnt % 4 == 0) || (ready_cnt % 4 == 3);
        ready_cnt++;
      end
      default: in_ready_i = 1'b1;
    endcase
  end

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    @(posedge clk_i);
    #1;
    out_data_i  = b;
    out_valid_i = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i);
      if (out_ready_o) begin
        @(posedge clk_i);
        #1;
        done = 1'b1;
      end
    end
    out_valid_i = 1'b0;
    check("send_timeout", done, 1);
  endtask

  task automatic send_line(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk_i);
      #1;
      if (exp_q.size() == 0) ok = 1'b1;
    end
    check("idle_timeout", ok, 1);
  endtask

  task automatic check_cap(input string name, input logic [7:0] exp[$]);
    check({name, "_count"}, cap_q.size(), exp.size());
    foreach (exp[i]) begin
      if (i < cap_q.size()) check({name, "_byte"}, cap_q[i], exp[i]);
    end
  endtask

  logic [7:0] line_q[$];
  logic [7:0] want_q[$];
  int         busy_cnt;

  initial begin
    rstn_i      = 1'b0;
    out_valid_i = 1'b0;
    out_data_i  = 8'h00;
    in_ready_i  = 1'b1;
    repeat (3) @(negedge clk_i);
    #2 rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("ready_after_reset", out_ready_o, 1);

    // "AB\r" with the host always ready.
    cap_q.delete();
    line_q = '{8'h41, 8'h42, 8'h0D};
    send_line(line_q);
    wait_idle();
    want_q = '{8'h41, 8'h42, 8'h0D};
    if (CRLF) want_q.push_back(8'h0A);
    check_cap("ab_cr", want_q);
    check("ab_cr_lines", lines_o, 1);

    // Empty line: a lone terminator; busy only while it is echoed.
    cap_q.delete();
    send_byte(TERM);
    busy_cnt = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (busy_o) busy_cnt++;
    end
    check("empty_busy_cycles", busy_cnt, CRLF ? 2 : 1);
    want_q = '{8'h0D};
    if (CRLF) want_q.push_back(8'h0A);
    check_cap("empty_line", want_q);
    check("empty_lines", lines_o, 2);

    // Host stalls with ready pattern 1,0,0,1.
    ready_mode = 2;
    ready_cnt  = 0;
    cap_q.delete();
    line_q = '{8'h61, 8'h62, 8'h63, 8'h0D};
    send_line(line_q);
    wait_idle();
    want_q = '{8'h61, 8'h62, 8'h63, 8'h0D};
    if (CRLF) want_q.push_back(8'h0A);
    check_cap("stall", want_q);
    check("stall_lines", lines_o, 3);

    // Nine bytes into an eight-byte buffer: the ninth waits for the replay.
    ready_mode = 0;
    cap_q.delete();
    line_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_line(line_q);
    check("full_lines", lines_o, 4);
    send_byte(TERM);
    wait_idle();
    want_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h0D};
    if (CRLF) want_q.push_back(8'h0A);
    check_cap("full", want_q);
    check("full_lines_after", lines_o, 5);

    // Line counter wrap.
    @(posedge clk_i);
    #1;
    dut.r_lines = 16'hFFFF;
    m_lines     = 16'hFFFF;
    send_byte(TERM);
    wait_idle();
    check("lines_wrap", lines_o, 0);

    // Randomized traffic with a random host.
    ready_mode = 1;
    for (int n = 0; n < 400; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      if ($urandom_range(0, 3) == 0) send_byte(TERM);
      else send_byte(8'($urandom_range(0, 255)));
    end
    send_byte(TERM);
    wait_idle();

    // Reset in the middle of replaying "HELLO\r".
    ready_mode = 0;
    line_q = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D};
    send_line(line_q);
    @(negedge clk_i);
    @(negedge clk_i);
    #1 rstn_i = 1'b0;
    #1;
    check("abort_in_valid", in_valid_o, 0);
    check("abort_lines", lines_o, 0);
    check("abort_out_ready", out_ready_o, 0);
    repeat (2) @(negedge clk_i);
    #1 rstn_i = 1'b1;
    cap_q.delete();
    line_q = '{8'h58, 8'h0D};
    send_line(line_q);
    wait_idle();
    want_q = '{8'h58, 8'h0D};
    if (CRLF) want_q.push_back(8'h0A);
    check_cap("after_abort", want_q);
    check("after_abort_lines", lines_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
